// File: rtl/alu_ctrl_sequencer_if.sv
// Control bundle between the ALU control sequencer and the datapath:
// IR/run into the sequencer, register/bus/ALU strobes and status out of it.
interface alu_ctrl_sequencer_if;
  logic        run;
  logic [31:0] IR;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic        PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin;
  logic        Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
  logic        ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL, NEG, NOT, MUL, DIV;
  logic        busy, done, illegal;
  logic [15:0] instr_cnt;

  modport master (
    input  run, IR,
    output Rin, Rout,
    output PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
    output Read, MDRin, MDRout, IRin, Yin, HIin, LOin,
    output ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL, NEG, NOT, MUL, DIV,
    output busy, done, illegal, instr_cnt
  );

  modport slave (
    output run, IR,
    input  Rin, Rout,
    input  PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
    input  Read, MDRin, MDRout, IRin, Yin, HIin, LOin,
    input  ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL, NEG, NOT, MUL, DIV,
    input  busy, done, illegal, instr_cnt
  );
endinterface

// File: rtl/alu_ctrl_sequencer.sv
// Hardwired fetch/execute control sequencer for ALU instructions. Outputs are a
// Moore decode of the current state and the IR fields; only state and counter are registered.
module alu_ctrl_sequencer #(
  parameter int OPW = 5,
  parameter int RW  = 4
) (
  input  logic                 clock,
  input  logic                 clear,
  alu_ctrl_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
  } state_t;

  typedef enum logic [1:0] {
    CLS_BIN, CLS_UNARY, CLS_MULDIV, CLS_ILL
  } cls_t;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_ROR  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_SHRA = OPW'(5'b00111);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b01000);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b10000);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10001);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10010);

  state_t          state, state_nxt;
  cls_t            cls;
  logic [OPW-1:0]  opcode;
  logic [RW-1:0]   ra, rb, rc;
  logic            op_en;
  logic            last;
  logic [15:0]     instr_cnt;
  logic            unused_ir;

  function automatic logic [15:0] onehot(input logic [RW-1:0] f);
    onehot = 16'(1) << f;
  endfunction

  assign opcode    = bus.IR[31 -: OPW];
  assign ra        = bus.IR[26 -: RW];
  assign rb        = bus.IR[22 -: RW];
  assign rc        = bus.IR[18 -: RW];
  assign unused_ir = ^bus.IR[14:0];

  always_comb begin
    cls = CLS_ILL;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:        cls = CLS_BIN;
      OP_NEG, OP_NOT:                         cls = CLS_UNARY;
      OP_MUL, OP_DIV:                         cls = CLS_MULDIV;
      default:                                cls = CLS_ILL;
    endcase
  end

  // The state that finishes an instruction depends on its class.
  assign last = (state == T4 && cls == CLS_UNARY) ||
                (state == T5 && cls == CLS_BIN)   ||
                (state == T6);

  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= IDLE;
      instr_cnt <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (last) instr_cnt <= instr_cnt + 16'h0001;
    end
  end

  assign bus.instr_cnt = instr_cnt;
  assign bus.busy      = (state != IDLE) && (state != HALT);
  assign bus.illegal   = (state == HALT);
  assign bus.done      = last;

  always_comb begin
    state_nxt    = state;
    op_en        = 1'b0;
    bus.Rin      = 16'h0000;
    bus.Rout     = 16'h0000;
    bus.PCout    = 1'b0;
    bus.MARin    = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Zin      = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.PCin     = 1'b0;
    bus.Read     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;

    case (state)
      IDLE: if (bus.run) state_nxt = T0;
      T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
        state_nxt = T1;
      end
      T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
        state_nxt   = T2;
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_nxt  = T3;
      end
      T3: begin
        case (cls)
          CLS_UNARY: begin
            bus.Rout = onehot(rb);
            op_en    = 1'b1;
            bus.Zin  = 1'b1;
            state_nxt = T4;
          end
          CLS_BIN, CLS_MULDIV: begin
            bus.Rout  = onehot(rb);
            bus.Yin   = 1'b1;
            state_nxt = T4;
          end
          default: state_nxt = HALT;
        endcase
      end
      T4: begin
        if (cls == CLS_UNARY) begin
          bus.Zlowout = 1'b1;
          bus.Rin     = onehot(ra);
          state_nxt   = bus.run ? T0 : IDLE;
        end else begin
          bus.Rout  = onehot(rc);
          op_en     = 1'b1;
          bus.Zin   = 1'b1;
          state_nxt = T5;
        end
      end
      T5: begin
        bus.Zlowout = 1'b1;
        if (cls == CLS_MULDIV) begin
          bus.LOin  = 1'b1;
          state_nxt = T6;
        end else begin
          bus.Rin   = onehot(ra);
          state_nxt = bus.run ? T0 : IDLE;
        end
      end
      T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
        state_nxt    = bus.run ? T0 : IDLE;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU select follows the opcode only in the states that load Z with an ALU result.
  always_comb begin
    bus.ADD  = 1'b0;
    bus.SUB  = 1'b0;
    bus.AND  = 1'b0;
    bus.OR   = 1'b0;
    bus.ROR  = 1'b0;
    bus.ROL  = 1'b0;
    bus.SHR  = 1'b0;
    bus.SHRA = 1'b0;
    bus.SHL  = 1'b0;
    bus.NEG  = 1'b0;
    bus.NOT  = 1'b0;
    bus.MUL  = 1'b0;
    bus.DIV  = 1'b0;
    if (op_en) begin
      case (opcode)
        OP_ADD:  bus.ADD  = 1'b1;
        OP_SUB:  bus.SUB  = 1'b1;
        OP_AND:  bus.AND  = 1'b1;
        OP_OR:   bus.OR   = 1'b1;
        OP_ROR:  bus.ROR  = 1'b1;
        OP_ROL:  bus.ROL  = 1'b1;
        OP_SHR:  bus.SHR  = 1'b1;
        OP_SHRA: bus.SHRA = 1'b1;
        OP_SHL:  bus.SHL  = 1'b1;
        OP_NEG:  bus.NEG  = 1'b1;
        OP_NOT:  bus.NOT  = 1'b1;
        OP_MUL:  bus.MUL  = 1'b1;
        OP_DIV:  bus.DIV  = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Directed bench for alu_ctrl_sequencer: walks fetch/execute for binary, unary,
// MUL and illegal opcodes, plus reset and mid-instruction clear.
module tb_alu_ctrl_sequencer;

  // Strobe masks, order {PCout,MARin,IncPC,Zin,Zlowout,Zhighout,PCin,Read,MDRin,MDRout,IRin,Yin,HIin,LOin}
  localparam logic [13:0] PCOUT = 14'h2000, MARIN = 14'h1000, INCPC  = 14'h0800, ZIN  = 14'h0400;
  localparam logic [13:0] ZLO   = 14'h0200, ZHI   = 14'h0100, PCIN   = 14'h0080, READ = 14'h0040;
  localparam logic [13:0] MDRIN = 14'h0020, MDROUT = 14'h0010, IRIN  = 14'h0008, YIN  = 14'h0004;
  localparam logic [13:0] HIIN  = 14'h0002, LOIN  = 14'h0001;
  // ALU masks, order {ADD,SUB,AND,OR,ROR,ROL,SHR,SHRA,SHL,NEG,NOT,MUL,DIV}
  localparam logic [12:0] A_ADD = 13'h1000, A_SUB = 13'h0800, A_ROR = 13'h0100;
  localparam logic [12:0] A_NEG = 13'h0008, A_MUL = 13'h0002;
  // Status {busy,done,illegal}
  localparam logic [2:0] ST_IDLE = 3'b000, ST_BUSY = 3'b100, ST_DONE = 3'b110, ST_HALT = 3'b001;

  logic clock;
  logic clear;
  int   compared;
  int   mismatched;

  alu_ctrl_sequencer_if bus ();

  alu_ctrl_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [13:0] strb();
    strb = {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.Zlowout, bus.Zhighout, bus.PCin,
            bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.HIin, bus.LOin};
  endfunction

  function automatic logic [12:0] ops();
    ops = {bus.ADD, bus.SUB, bus.AND, bus.OR, bus.ROR, bus.ROL, bus.SHR, bus.SHRA,
           bus.SHL, bus.NEG, bus.NOT, bus.MUL, bus.DIV};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] rin, input logic [15:0] rout,
                           input logic [13:0] s, input logic [12:0] o, input logic [2:0] st,
                           input logic [15:0] cnt);
    check({tag, ".Rin"},  32'(bus.Rin),  32'(rin));
    check({tag, ".Rout"}, 32'(bus.Rout), 32'(rout));
    check({tag, ".strb"}, 32'(strb()),   32'(s));
    check({tag, ".alu"},  32'(ops()),    32'(o));
    check({tag, ".stat"}, 32'({bus.busy, bus.done, bus.illegal}), 32'(st));
    check({tag, ".cnt"},  32'(bus.instr_cnt), 32'(cnt));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [15:0] cnt);
    step();
    check_all({tag, ".T0"}, 16'h0, 16'h0, PCOUT | MARIN | INCPC | ZIN, 13'h0, ST_BUSY, cnt);
    step();
    check_all({tag, ".T1"}, 16'h0, 16'h0, ZLO | PCIN | READ | MDRIN, 13'h0, ST_BUSY, cnt);
    step();
    check_all({tag, ".T2"}, 16'h0, 16'h0, MDROUT | IRIN, 13'h0, ST_BUSY, cnt);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    clear      = 1'b1;
    bus.run    = 1'b0;
    bus.IR     = 32'h0;

    step();
    step();
    check_all("reset", 16'h0, 16'h0, 14'h0, 13'h0, ST_IDLE, 16'h0);
    clear = 1'b0;
    step();
    check_all("idle", 16'h0, 16'h0, 14'h0, 13'h0, ST_IDLE, 16'h0);

    // ROR R7,R0,R4; run dropped during T4 must still complete
    bus.IR  = 32'h23820000;
    bus.run = 1'b1;
    fetch("ror", 16'd0);
    step();
    check_all("ror.T3", 16'h0, 16'h0001, YIN, 13'h0, ST_BUSY, 16'd0);
    step();
    check_all("ror.T4", 16'h0, 16'h0010, ZIN, A_ROR, ST_BUSY, 16'd0);
    bus.run = 1'b0;
    step();
    check_all("ror.T5", 16'h0080, 16'h0, ZLO, 13'h0, ST_DONE, 16'd0);
    step();
    check_all("ror.end", 16'h0, 16'h0, 14'h0, 13'h0, ST_IDLE, 16'd1);

    // ADD R3,R1,R2 twice back-to-back
    bus.IR  = 32'h01890000;
    bus.run = 1'b1;
    fetch("add1", 16'd1);
    step();
    check_all("add1.T3", 16'h0, 16'h0002, YIN, 13'h0, ST_BUSY, 16'd1);
    step();
    check_all("add1.T4", 16'h0, 16'h0004, ZIN, A_ADD, ST_BUSY, 16'd1);
    step();
    check_all("add1.T5", 16'h0008, 16'h0, ZLO, 13'h0, ST_DONE, 16'd1);
    fetch("add2", 16'd2);
    step();
    check_all("add2.T3", 16'h0, 16'h0002, YIN, 13'h0, ST_BUSY, 16'd2);
    step();
    check_all("add2.T4", 16'h0, 16'h0004, ZIN, A_ADD, ST_BUSY, 16'd2);
    bus.run = 1'b0;
    step();
    check_all("add2.T5", 16'h0008, 16'h0, ZLO, 13'h0, ST_DONE, 16'd2);
    step();
    check_all("add2.end", 16'h0, 16'h0, 14'h0, 13'h0, ST_IDLE, 16'd3);

    // NEG R2,R9: done in T4
    bus.IR  = 32'h89480000;
    bus.run = 1'b1;
    fetch("neg", 16'd3);
    step();
    check_all("neg.T3", 16'h0, 16'h0200, ZIN, A_NEG, ST_BUSY, 16'd3);
    bus.run = 1'b0;
    step();
    check_all("neg.T4", 16'h0004, 16'h0, ZLO, 13'h0, ST_DONE, 16'd3);
    step();
    check_all("neg.end", 16'h0, 16'h0, 14'h0, 13'h0, ST_IDLE, 16'd4);

    // MUL with IR=0x7AC00000: Rb field 8, Rc field 0
    bus.IR  = 32'h7AC00000;
    bus.run = 1'b1;
    fetch("mul", 16'd4);
    step();
    check_all("mul.T3", 16'h0, 16'h0100, YIN, 13'h0, ST_BUSY, 16'd4);
    step();
    check_all("mul.T4", 16'h0, 16'h0001, ZIN, A_MUL, ST_BUSY, 16'd4);
    bus.run = 1'b0;
    step();
    check_all("mul.T5", 16'h0, 16'h0, ZLO | LOIN, 13'h0, ST_BUSY, 16'd4);
    step();
    check_all("mul.T6", 16'h0, 16'h0, ZHI | HIIN, 13'h0, ST_DONE, 16'd4);
    step();
    check_all("mul.end", 16'h0, 16'h0, 14'h0, 13'h0, ST_IDLE, 16'd5);

    // Illegal opcode 11111 -> HALT until clear
    bus.IR  = 32'hF8000000;
    bus.run = 1'b1;
    fetch("ill", 16'd5);
    step();
    check_all("ill.T3", 16'h0, 16'h0, 14'h0, 13'h0, ST_BUSY, 16'd5);
    step();
    check_all("ill.halt", 16'h0, 16'h0, 14'h0, 13'h0, ST_HALT, 16'd5);
    step();
    check_all("ill.hold", 16'h0, 16'h0, 14'h0, 13'h0, ST_HALT, 16'd5);
    clear   = 1'b1;
    bus.run = 1'b0;
    step();
    check_all("ill.clear", 16'h0, 16'h0, 14'h0, 13'h0, ST_IDLE, 16'd0);
    clear = 1'b0;
    step();
    check_all("ill.idle", 16'h0, 16'h0, 14'h0, 13'h0, ST_IDLE, 16'd0);

    // SUB R1,R2,R3 aborted by clear in T4
    bus.IR  = 32'h08918000;
    bus.run = 1'b1;
    fetch("sub", 16'd0);
    step();
    check_all("sub.T3", 16'h0, 16'h0004, YIN, 13'h0, ST_BUSY, 16'd0);
    step();
    check_all("sub.T4", 16'h0, 16'h0008, ZIN, A_SUB, ST_BUSY, 16'd0);
    clear   = 1'b1;
    bus.run = 1'b0;
    step();
    check_all("sub.abort", 16'h0, 16'h0, 14'h0, 13'h0, ST_IDLE, 16'd0);
    clear = 1'b0;
    step();
    check_all("sub.idle", 16'h0, 16'h0, 14'h0, 13'h0, ST_IDLE, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
